// File: rtl/chip_checker_spi_pkg.sv
// Shared constants for the chip-checker SPI sequencer: core register map,
// control-register bit positions and the sequencer state encoding.
package chip_checker_spi_pkg;

    localparam logic [2:0] RXDATA   = 3'd0;
    localparam logic [2:0] TXDATA   = 3'd1;
    localparam logic [2:0] STATUS   = 3'd2;
    localparam logic [2:0] CONTROL  = 3'd3;
    localparam logic [2:0] SLAVESEL = 3'd5;
    localparam logic [2:0] EOPVAL   = 3'd6;

    localparam int SSO = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_STAT,
        ST_SET_SS,
        ST_SSO_ON,
        ST_WAIT_TX,
        ST_WAIT_TRDY,
        ST_WR_DATA,
        ST_WAIT_RRDY,
        ST_RD_DATA,
        ST_RX_OUT,
        ST_SSO_OFF,
        ST_DONE
    } state_e;

    // Control word with only SSO possibly set; interrupt enables stay clear.
    function automatic logic [15:0] ctrl_word(input logic sso_on);
        logic [15:0] w;
        w      = '0;
        w[SSO] = sso_on;
        return w;
    endfunction

endpackage

// File: rtl/chip_checker_spi_bus_access.sv
// Two-cycle register access engine for the SPI core. A start on the ack cycle
// chains the next access with no idle cycle in between.
module chip_checker_spi_bus_access
    import chip_checker_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] wdata_i,
    input  logic        is_read_i,
    output logic        ack_o,
    output logic [15:0] rdata_o,
    output logic        spi_select_o,
    output logic [2:0]  spi_addr_o,
    output logic [15:0] spi_wdata_o,
    output logic        spi_read_n_o,
    output logic        spi_write_n_o,
    input  logic [15:0] spi_rdata_i
);

    logic sel_q;
    logic phase_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        read_n_q;
    logic        write_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= 1'b0;
            phase_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
        end else if (start_i && (!sel_q || phase_q)) begin
            sel_q     <= 1'b1;
            phase_q   <= 1'b0;
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            read_n_q  <= !is_read_i;
            write_n_q <= is_read_i;
        end else if (sel_q && !phase_q) begin
            phase_q <= 1'b1;
        end else if (sel_q) begin
            sel_q     <= 1'b0;
            phase_q   <= 1'b0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
        end
    end

    assign ack_o         = sel_q && phase_q;
    assign rdata_o       = spi_rdata_i;
    assign spi_select_o  = sel_q;
    assign spi_addr_o    = addr_q;
    assign spi_wdata_o   = wdata_q;
    assign spi_read_n_o  = read_n_q;
    assign spi_write_n_o = write_n_q;

endmodule

// File: rtl/chip_checker_spi_seq.sv
// Burst sequencer driving the SPI core register port: clears status, raises
// SSO, exchanges each byte full-duplex, then drops SSO and pulses done.
module chip_checker_spi_seq
    import chip_checker_spi_pkg::*;
#(
    parameter int          LEN_W   = 8,
    parameter logic [15:0] SS_MASK = 16'h0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             spi_select,
    output logic [2:0]       spi_addr,
    output logic [15:0]      spi_wdata,
    output logic             spi_read_n,
    output logic             spi_write_n,
    input  logic [15:0]      spi_rdata,
    input  logic             spi_readyfordata,
    input  logic             spi_dataavailable
);

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       byte_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             done_q;

    logic        acc_start;
    logic [2:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_read;
    logic        acc_ack;
    logic [15:0] acc_rdata;
    logic        unused_rdata_hi;

    logic last_byte_out;
    assign last_byte_out = rx_valid_q && rx_ready && (len_q == LEN_W'(1));

    // Launch decode: the access for the next state starts on the same edge
    // the state advances, so accesses run back to back.
    always_comb begin
        acc_start = 1'b0;
        acc_addr  = RXDATA;
        acc_wdata = '0;
        acc_read  = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_len != '0) begin
                acc_start = 1'b1;
                acc_addr  = STATUS;
            end
            ST_CLR_STAT: if (acc_ack) begin
                acc_start = 1'b1;
                acc_addr  = SLAVESEL;
                acc_wdata = SS_MASK;
            end
            ST_SET_SS: if (acc_ack) begin
                acc_start = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctrl_word(1'b1);
            end
            ST_WAIT_TRDY: if (spi_readyfordata) begin
                acc_start = 1'b1;
                acc_addr  = TXDATA;
                acc_wdata = {8'h00, byte_q};
            end
            ST_WAIT_RRDY: if (spi_dataavailable) begin
                acc_start = 1'b1;
                acc_read  = 1'b1;
            end
            ST_RX_OUT: if (last_byte_out) begin
                acc_start = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctrl_word(1'b0);
            end
            default: ;
        endcase
    end

    chip_checker_spi_bus_access u_bus (
        .clk          (clk),
        .reset        (reset),
        .start_i      (acc_start),
        .addr_i       (acc_addr),
        .wdata_i      (acc_wdata),
        .is_read_i    (acc_read),
        .ack_o        (acc_ack),
        .rdata_o      (acc_rdata),
        .spi_select_o (spi_select),
        .spi_addr_o   (spi_addr),
        .spi_wdata_o  (spi_wdata),
        .spi_read_n_o (spi_read_n),
        .spi_write_n_o(spi_write_n),
        .spi_rdata_i  (spi_rdata)
    );

    assign unused_rdata_hi = ^acc_rdata[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            byte_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (cmd_valid) begin
                    len_q <= cmd_len;
                    if (cmd_len == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CLR_STAT;
                    end
                end
                ST_CLR_STAT:  if (acc_ack) state_q <= ST_SET_SS;
                ST_SET_SS:    if (acc_ack) state_q <= ST_SSO_ON;
                ST_SSO_ON:    if (acc_ack) state_q <= ST_WAIT_TX;
                ST_WAIT_TX: if (tx_valid) begin
                    byte_q  <= tx_data;
                    state_q <= ST_WAIT_TRDY;
                end
                ST_WAIT_TRDY: if (spi_readyfordata) state_q <= ST_WR_DATA;
                ST_WR_DATA:   if (acc_ack) state_q <= ST_WAIT_RRDY;
                ST_WAIT_RRDY: if (spi_dataavailable) state_q <= ST_RD_DATA;
                ST_RD_DATA: if (acc_ack) begin
                    rx_data_q  <= acc_rdata[7:0];
                    rx_valid_q <= 1'b1;
                    state_q    <= ST_RX_OUT;
                end
                // The next byte is only written once this one is consumed.
                ST_RX_OUT: if (rx_valid_q && rx_ready) begin
                    rx_valid_q <= 1'b0;
                    len_q      <= len_q - LEN_W'(1);
                    state_q    <= last_byte_out ? ST_SSO_OFF : ST_WAIT_TX;
                end
                ST_SSO_OFF: if (acc_ack) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign tx_ready  = (state_q == ST_WAIT_TX);
    assign busy      = (state_q != ST_IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_chip_checker_spi_seq.sv
// Directed bench for chip_checker_spi_seq with a loopback model of the SPI core
// register port (status flags, TRDY/RRDY, SSO and slave-select tracking).
module tb_chip_checker_spi_seq;

    localparam int SHIFT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_len = 8'd0;
    logic        cmd_ready;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        spi_select;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_rdata;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chip_checker_spi_seq #(.LEN_W(8), .SS_MASK(16'h0001)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_len          (cmd_len),
        .cmd_ready        (cmd_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .busy             (busy),
        .done             (done),
        .spi_select       (spi_select),
        .spi_addr         (spi_addr),
        .spi_wdata        (spi_wdata),
        .spi_read_n       (spi_read_n),
        .spi_write_n      (spi_write_n),
        .spi_rdata        (spi_rdata),
        .spi_readyfordata (spi_readyfordata),
        .spi_dataavailable(spi_dataavailable)
    );

    // ---------------- SPI core model (loopback MISO = MOSI) ----------------
    logic        m_ph, m_r1, m_w1n;
    logic [2:0]  m_a1;
    logic [15:0] m_wd1;
    logic        m_busy, m_rrdy, m_roe, m_toe, m_sso;
    logic [15:0] m_ssel;
    logic [7:0]  m_txd, m_rxd;
    int          m_cnt;
    logic [19:0] log_ent [0:255];
    int log_n = 0;
    int unstable = 0;
    int ctl_bad = 0;
    int sel_cycles = 0;
    int ss_bad = 0;
    int tx_writes = 0;

    assign spi_readyfordata  = !m_busy;
    assign spi_dataavailable = m_rrdy;

    always_comb begin
        spi_rdata = 16'h0000;
        if (spi_addr == 3'd0) spi_rdata = {8'h00, m_rxd};
        else if (spi_addr == 3'd2) spi_rdata = {8'h00, m_rrdy, !m_busy, !m_busy, m_toe, m_roe, 3'b000};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= 1'b0; m_r1 <= 1'b1; m_w1n <= 1'b1; m_a1 <= 3'd0; m_wd1 <= 16'h0;
            m_busy <= 1'b0; m_rrdy <= 1'b0; m_roe <= 1'b0; m_toe <= 1'b0; m_sso <= 1'b0;
            m_ssel <= 16'h0; m_txd <= 8'h0; m_rxd <= 8'h0; m_cnt <= 0;
        end else begin
            if (spi_select) sel_cycles <= sel_cycles + 1;
            if ((m_busy || m_rrdy) && !(m_sso && m_ssel[0])) ss_bad <= ss_bad + 1;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_rxd  <= m_txd;
                    m_rrdy <= 1'b1;
                    if (m_rrdy) m_roe <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (spi_select && !m_ph) begin
                m_ph <= 1'b1; m_a1 <= spi_addr; m_wd1 <= spi_wdata;
                m_r1 <= spi_read_n; m_w1n <= spi_write_n;
            end else if (spi_select) begin
                m_ph <= 1'b0;
                if (m_a1 !== spi_addr || m_wd1 !== spi_wdata || m_r1 !== spi_read_n || m_w1n !== spi_write_n)
                    unstable <= unstable + 1;
                log_ent[log_n[7:0]] <= !spi_read_n ? {1'b1, spi_addr, 16'h0000} : {1'b0, spi_addr, spi_wdata};
                log_n <= log_n + 1;
                if (!spi_write_n) begin
                    case (spi_addr)
                        3'd1: begin
                            if (m_busy) m_toe <= 1'b1;
                            m_txd <= spi_wdata[7:0]; m_busy <= 1'b1; m_cnt <= SHIFT;
                            tx_writes <= tx_writes + 1;
                        end
                        3'd2: begin m_roe <= 1'b0; m_toe <= 1'b0; end
                        3'd3: begin
                            m_sso <= spi_wdata[10];
                            if (spi_wdata[9:3] != 7'd0) ctl_bad <= ctl_bad + 1;
                        end
                        3'd5: m_ssel <= spi_wdata;
                        default: ;
                    endcase
                end else if (!spi_read_n && spi_addr == 3'd0) begin
                    m_rrdy <= 1'b0;
                end
            end
        end
    end

    // ---------------- burst driver ----------------
    logic [7:0] txb [0:3];
    logic [7:0] rxb [0:3];
    int  rx_n, dones, snap_wr, wr_base;
    logic first_sel, first_done, post_done, post_ready, snap_rxv, timed_out;

    task automatic run_burst(input int n, input int stall_idx, input int stall_cyc);
        int tx_idx, stall_ctr, cyc;
        logic hs_tx, hs_rx;
        tx_idx = 0; rx_n = 0; dones = 0; stall_ctr = 0; cyc = 0;
        snap_wr = -1; snap_rxv = 1'b0; timed_out = 1'b0; wr_base = tx_writes;
        @(negedge clk);
        cmd_len = n[7:0];
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        first_sel = spi_select;
        first_done = done;
        while (cyc < 3000) begin
            if (done) begin
                dones++;
                break;
            end
            tx_valid = (tx_idx < n);
            tx_data  = (tx_idx < n) ? txb[tx_idx] : 8'h00;
            if (rx_n == stall_idx && rx_valid && stall_ctr < stall_cyc) begin
                rx_ready = 1'b0;
                stall_ctr++;
                if (stall_ctr == stall_cyc) begin
                    snap_wr  = tx_writes - wr_base;
                    snap_rxv = rx_valid;
                end
            end else begin
                rx_ready = 1'b1;
            end
            hs_tx = tx_valid && tx_ready;
            hs_rx = rx_valid && rx_ready;
            if (hs_rx && rx_n < 4) rxb[rx_n] = rx_data;
            @(posedge clk);
            if (hs_tx) tx_idx++;
            if (hs_rx) rx_n++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) timed_out = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        post_done  = done;
        post_ready = cmd_ready;
        if (done) dones++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        checks += 11;
        if (cmd_ready !== 1'b1)   begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        if (tx_ready !== 1'b0)    begin failures++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
        if (rx_valid !== 1'b0)    begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        if (rx_data !== 8'h00)    begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        if (spi_select !== 1'b0)  begin failures++; $display("FAIL rst_select got=%b exp=0", spi_select); end
        if (spi_addr !== 3'd0)    begin failures++; $display("FAIL rst_addr got=%0d exp=0", spi_addr); end
        if (spi_wdata !== 16'h0)  begin failures++; $display("FAIL rst_wdata got=%h exp=0000", spi_wdata); end
        if (spi_read_n !== 1'b1)  begin failures++; $display("FAIL rst_read_n got=%b exp=1", spi_read_n); end
        if (spi_write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n got=%b exp=1", spi_write_n); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (spi_read_n !== 1'b1 || spi_write_n !== 1'b1) begin
                failures++;
                $display("FAIL idle_strobes cyc=%0d got rd_n=%b wr_n=%b exp=1/1", i, spi_read_n, spi_write_n);
            end
        end
    endtask

    task automatic test_single_byte;
        logic [19:0] exp_seq [0:5];
        int base;
        exp_seq[0] = {1'b0, 3'd2, 16'h0000};
        exp_seq[1] = {1'b0, 3'd5, 16'h0001};
        exp_seq[2] = {1'b0, 3'd3, 16'h0400};
        exp_seq[3] = {1'b0, 3'd1, 16'h00A5};
        exp_seq[4] = {1'b1, 3'd0, 16'h0000};
        exp_seq[5] = {1'b0, 3'd3, 16'h0000};
        base = log_n;
        txb[0] = 8'hA5;
        run_burst(1, -1, 0);
        checks += 8;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL b1_timeout got=%b exp=0", timed_out); end
        if (first_sel !== 1'b1) begin failures++; $display("FAIL b1_sel_latency got=%b exp=1", first_sel); end
        if (log_n - base != 6)  begin failures++; $display("FAIL b1_access_count got=%0d exp=6", log_n - base); end
        if (rx_n != 1)          begin failures++; $display("FAIL b1_rx_count got=%0d exp=1", rx_n); end
        if (rxb[0] !== 8'hA5)   begin failures++; $display("FAIL b1_rx_data got=%h exp=a5", rxb[0]); end
        if (dones != 1)         begin failures++; $display("FAIL b1_done_pulses got=%0d exp=1", dones); end
        if (post_ready !== 1'b1) begin failures++; $display("FAIL b1_cmd_ready_after got=%b exp=1", post_ready); end
        if (unstable != 0)      begin failures++; $display("FAIL b1_access_stable got=%0d exp=0", unstable); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_ent[(base + i) % 256] !== exp_seq[i]) begin
                failures++;
                $display("FAIL b1_access%0d got=%h exp=%h", i, log_ent[(base + i) % 256], exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall;
        int base, ssb;
        base = log_n;
        ssb = ss_bad;
        txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03;
        run_burst(3, 1, 50);
        checks += 11;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL b3_timeout got=%b exp=0", timed_out); end
        if (snap_wr != 2)       begin failures++; $display("FAIL b3_writes_during_stall got=%0d exp=2", snap_wr); end
        if (snap_rxv !== 1'b1)  begin failures++; $display("FAIL b3_rx_valid_held got=%b exp=1", snap_rxv); end
        if (rx_n != 3)          begin failures++; $display("FAIL b3_rx_count got=%0d exp=3", rx_n); end
        if (rxb[0] !== 8'h01 || rxb[1] !== 8'h02 || rxb[2] !== 8'h03) begin
            failures++; $display("FAIL b3_rx_bytes got=%h %h %h exp=01 02 03", rxb[0], rxb[1], rxb[2]);
        end
        if (m_roe !== 1'b0)     begin failures++; $display("FAIL b3_roe got=%b exp=0", m_roe); end
        if (m_toe !== 1'b0)     begin failures++; $display("FAIL b3_toe got=%b exp=0", m_toe); end
        if (ss_bad != ssb)      begin failures++; $display("FAIL b3_ss_n_low got=%0d exp=0", ss_bad - ssb); end
        if (log_n - base != 10) begin failures++; $display("FAIL b3_access_count got=%0d exp=10", log_n - base); end
        if (dones != 1)         begin failures++; $display("FAIL b3_done_pulses got=%0d exp=1", dones); end
        if (ctl_bad != 0)       begin failures++; $display("FAIL b3_ctrl_bits got=%0d exp=0", ctl_bad); end
    endtask

    task automatic test_zero_len;
        int base, sc;
        base = log_n;
        sc = sel_cycles;
        run_burst(0, -1, 0);
        checks += 5;
        if (first_done !== 1'b1) begin failures++; $display("FAIL z_done_latency got=%b exp=1", first_done); end
        if (dones != 1)          begin failures++; $display("FAIL z_done_pulses got=%0d exp=1", dones); end
        if (sel_cycles != sc)    begin failures++; $display("FAIL z_select_cycles got=%0d exp=0", sel_cycles - sc); end
        if (log_n != base)       begin failures++; $display("FAIL z_access_count got=%0d exp=0", log_n - base); end
        if (post_ready !== 1'b1) begin failures++; $display("FAIL z_cmd_ready_after got=%b exp=1", post_ready); end
    endtask

    task automatic test_reset_mid_burst;
        int base, cyc, tx_idx;
        logic [7:0] seq [0:2];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        base = tx_writes;
        tx_idx = 0;
        cyc = 0;
        @(negedge clk);
        cmd_len = 8'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (tx_writes - base < 2 && cyc < 2000) begin
            tx_valid = (tx_idx < 3);
            tx_data  = seq[tx_idx % 3];
            rx_ready = 1'b1;
            if (tx_valid && tx_ready) tx_idx++;
            @(negedge clk);
            cyc++;
        end
        tx_valid = 1'b0;
        checks += 13;
        if (cyc >= 2000) begin failures++; $display("FAIL mid_reach_byte2 got=timeout exp=2 writes"); end
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        #1 reset = 1'b1;
        #1;
        if (cmd_ready !== 1'b1)   begin failures++; $display("FAIL mid_cmd_ready got=%b exp=1", cmd_ready); end
        if (tx_ready !== 1'b0)    begin failures++; $display("FAIL mid_tx_ready got=%b exp=0", tx_ready); end
        if (rx_valid !== 1'b0)    begin failures++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
        if (rx_data !== 8'h00)    begin failures++; $display("FAIL mid_rx_data got=%h exp=00", rx_data); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
        if (spi_select !== 1'b0)  begin failures++; $display("FAIL mid_select got=%b exp=0", spi_select); end
        if (spi_addr !== 3'd0)    begin failures++; $display("FAIL mid_addr got=%0d exp=0", spi_addr); end
        if (spi_wdata !== 16'h0)  begin failures++; $display("FAIL mid_wdata got=%h exp=0000", spi_wdata); end
        if (spi_read_n !== 1'b1)  begin failures++; $display("FAIL mid_read_n got=%b exp=1", spi_read_n); end
        if (spi_write_n !== 1'b1) begin failures++; $display("FAIL mid_write_n got=%b exp=1", spi_write_n); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        txb[0] = 8'h3C;
        run_burst(1, -1, 0);
        checks += 3;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL post_timeout got=%b exp=0", timed_out); end
        if (rxb[0] !== 8'h3C || rx_n != 1) begin
            failures++; $display("FAIL post_rx got=%h n=%0d exp=3c n=1", rxb[0], rx_n);
        end
        if (dones != 1) begin failures++; $display("FAIL post_done_pulses got=%0d exp=1", dones); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back_stall();
        test_zero_len();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chip_checker_spi_seq.md
# chip_checker_spi_seq

Transfer sequencer sitting directly upstream of the platform SPI master core. It accepts a byte-count command plus a tx byte stream, and drives the core's register port (select, address, read/write strobes, write data) to perform a full-duplex burst. Slave select is held asserted across the whole burst via the control register's SSO bit, and every received byte is returned on an rx stream. This replaces CPU polling for the chip-checker's SPI device accesses.

## Interface
- LEN_W, 8: width of cmd_len; bursts of 0..2^LEN_W-1 bytes.
- SS_MASK, 16'h0001: value written to the slave-enable register (addr 5) at burst start.
- clk  in  1  system clock, same domain as the SPI core.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst request.
- cmd_len  in  LEN_W  byte count; sampled on cmd_valid & cmd_ready.
- cmd_ready  out  1  high in IDLE.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx byte available.
- tx_ready  out  1  high only in WAIT_TX.
- rx_data  out  8  received byte; held while rx_valid.
- rx_valid  out  1  rx byte pending.
- rx_ready  in  1  consumer accepts rx byte.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- spi_select  out  1  core chip-select.
- spi_addr  out  3  core register address.
- spi_wdata  out  16  core write data.
- spi_read_n, spi_write_n  out  1  active-low strobes.
- spi_rdata  in  16  core read data.
- spi_readyfordata, spi_dataavailable  in  1  core TRDY / RRDY.

## Operation
- Every bus access lasts exactly 2 cycles: spi_select, spi_addr, spi_wdata and the strobe are held constant for both; spi_rdata is sampled at the end of cycle 2. Back-to-back accesses need no idle cycle.
- States: IDLE -> CLR_STAT (write addr 2, data 0: clear stale status) -> SET_SS (write addr 5, SS_MASK) -> SSO_ON (write addr 3, 16'h0400) -> per byte: WAIT_TX -> WAIT_TRDY -> WR_DATA (write addr 1, {8'h0,byte}) -> WAIT_RRDY -> RD_DATA (read addr 0) -> RX_OUT -> next byte or SSO_OFF (write addr 3, 16'h0000) -> DONE -> IDLE.
- cmd_len == 0: IDLE -> DONE directly; no bus access; done pulses.
- WAIT_TX: tx_ready=1; on tx_valid the byte is latched; go to WAIT_TRDY.
- WAIT_TRDY / WAIT_RRDY: stay until spi_readyfordata / spi_dataavailable is sampled high.
- RD_DATA: spi_rdata[7:0] is loaded into rx_data and rx_valid is set at the end of cycle 2.
- RX_OUT: hold until rx_valid & rx_ready; rx_valid clears on that edge. The remaining-byte counter then decrements. The next byte is never written before the previous rx byte is consumed, so the core never sees ROE/TOE.
- Interrupt enables are never set; all control writes keep bits 9:3 = 0.
- Reset mid-burst: the sequencer returns to IDLE immediately. The SPI core is on the same reset, so SSO clears with it.

## Timing
- Reset values: cmd_ready=1, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, spi_select=0, spi_addr=0, spi_wdata=0, spi_read_n=1, spi_write_n=1.
- All outputs are registered except cmd_ready, tx_ready and busy, which are decoded from state.
- cmd accept -> first spi_select: 1 cycle.
- Burst overhead: 6 setup cycles (3 accesses) + 2 teardown cycles + 1 DONE cycle.
- Per byte with zero stall: 1 WAIT_TX + ≥1 WAIT_TRDY + 2 WR + SPI shift time + 2 RD + 1 RX_OUT cycle.
- done asserts in the cycle after SSO_OFF cycle 2; cmd_ready returns the following cycle.
- A cmd_valid arriving while busy is ignored (not latched).

## Structure
- Package chip_checker_spi_pkg holds:
  - register address constants: RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3, SLAVESEL=5, EOPVAL=6;
  - control bit SSO=10;
  - the state enum.
- One sub-module, chip_checker_spi_bus_access: the 2-cycle access engine. It takes start/addr/wdata/is_read and returns rdata plus an ack pulse on cycle 2. The top-level FSM reuses it for all six access types.

## Test plan
- Reset: outputs take the listed reset values; spi_read_n and spi_write_n stay 1 for 10 cycles with cmd_valid low.
- 1-byte burst, tx 8'hA5, loopback MISO=MOSI: write sequence addr 2, 5 (16'h0001), 3 (16'h0400), 1 (16'h00A5), read addr 0, write addr 3 (16'h0000). rx_data=8'hA5; done pulses once.
- 3-byte burst 8'h01,8'h02,8'h03 with rx_ready held low 50 cycles on byte 2: no addr-1 write until rx byte 2 is consumed; core status shows ROE=0 and TOE=0; SS_n stays low throughout.
- cmd_len=0: done pulses 1 cycle after accept; no spi_select activity.
- Reset asserted during WAIT_RRDY of byte 2: outputs return to reset values asynchronously; a new 1-byte burst afterwards completes normally.
